// File: rtl/pwm_phase_sequencer.sv
// Half-bridge leg sequencer: PWM period counter, SPDT requests, shadowed config applied at period wrap,
// enable drain and latched fault. Outputs are registered (one cycle after inputs); CfgReady low while shadow full.
module pwm_phase_sequencer #(
    parameter int unsigned W          = 16,
    parameter int unsigned RST_PERIOD = 100,
    parameter int unsigned RST_DUTY   = 50,
    parameter int unsigned RST_DEAD   = 5
) (
    input  logic         MClk_i,
    input  logic         RstN_i,
    input  logic         Enable_i,
    input  logic         Fault_i,
    input  logic         FaultClr_i,
    input  logic         CfgValid_i,
    output logic         CfgReady_o,
    input  logic [W-1:0] CfgPeriod_i,
    input  logic [W-1:0] CfgDuty_i,
    input  logic [W-1:0] CfgDead_i,
    output logic [1:0]   SPDT_o,
    output logic [W-1:0] DeadTimeCount_o,
    output logic         PeriodStart_o,
    output logic         Running_o,
    output logic         FaultLatched_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FAULT} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   drain_q, drain_d;
    logic [W-1:0]   period_a_q, period_a_d, duty_a_q, duty_a_d, dead_a_q, dead_a_d;
    logic [W-1:0]   period_p_q, period_p_d, duty_p_q, duty_p_d, dead_p_q, dead_p_d;
    logic           pend_q, pend_d;
    logic [1:0]     spdt_q, spdt_d;
    logic           ps_q, ps_d, run_q, run_d, flt_q, flt_d;
    logic           wrap, apply, accept;

    assign wrap   = (cnt_q == period_a_q - W'(1));
    assign apply  = pend_q && ((state_q == RUN && wrap) || state_q == IDLE || state_q == FAULT);
    assign accept = CfgValid_i && !pend_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        period_a_d = period_a_q;
        duty_a_d   = duty_a_q;
        dead_a_d   = dead_a_q;
        period_p_d = period_p_q;
        duty_p_d   = duty_p_q;
        dead_p_d   = dead_p_q;
        pend_d     = pend_q;

        if (apply) begin
            period_a_d = period_p_q;
            duty_a_d   = duty_p_q;
            dead_a_d   = dead_p_q;
            pend_d     = 1'b0;
        end
        // A period below 2 would leave no low phase to drain into; clamp on entry to the shadow.
        if (accept) begin
            period_p_d = (CfgPeriod_i < W'(2)) ? W'(2) : CfgPeriod_i;
            duty_p_d   = CfgDuty_i;
            dead_p_d   = CfgDead_i;
            pend_d     = 1'b1;
        end

        if (Fault_i) begin
            state_d = FAULT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (Enable_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
                RUN: if (!Enable_i) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    drain_d = dead_a_q;
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + W'(1);
                end
                DRAIN: if (drain_q == '0) state_d = IDLE;
                       else               drain_d = drain_q - W'(1);
                FAULT: if (FaultClr_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        spdt_d = 2'b00;
        if (state_d == RUN) spdt_d = (cnt_d < duty_a_d) ? 2'b10 : 2'b01;
        ps_d  = (state_d == RUN) && (cnt_d == '0);
        run_d = (state_d == RUN) || (state_d == DRAIN);
        flt_d = (state_d == FAULT);
    end

    always_ff @(posedge MClk_i) begin
        if (!RstN_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drain_q    <= '0;
            period_a_q <= W'(RST_PERIOD);
            duty_a_q   <= W'(RST_DUTY);
            dead_a_q   <= W'(RST_DEAD);
            period_p_q <= W'(RST_PERIOD);
            duty_p_q   <= W'(RST_DUTY);
            dead_p_q   <= W'(RST_DEAD);
            pend_q     <= 1'b0;
            spdt_q     <= 2'b00;
            ps_q       <= 1'b0;
            run_q      <= 1'b0;
            flt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            period_a_q <= period_a_d;
            duty_a_q   <= duty_a_d;
            dead_a_q   <= dead_a_d;
            period_p_q <= period_p_d;
            duty_p_q   <= duty_p_d;
            dead_p_q   <= dead_p_d;
            pend_q     <= pend_d;
            spdt_q     <= spdt_d;
            ps_q       <= ps_d;
            run_q      <= run_d;
            flt_q      <= flt_d;
        end
    end

    assign CfgReady_o      = !pend_q;
    assign DeadTimeCount_o = dead_a_q;
    assign SPDT_o          = spdt_q;
    assign PeriodStart_o   = ps_q;
    assign Running_o       = run_q;
    assign FaultLatched_o  = flt_q;

endmodule

// File: tb/tb_pwm_phase_sequencer.sv
// Bench for pwm_phase_sequencer: per-cycle vectors with expected outputs queued at drive time, checked after the edge.
module tb_pwm_phase_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstn, en, flt, fclr, cv;
    logic [W-1:0] cp, cd, cdd;
    logic         rdy, ps, running, flatched;
    logic [1:0]   spdt;
    logic [W-1:0] dtc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           rstn, en, flt, fclr, cv;
        logic [W-1:0] cp, cd, cdd;
        logic [1:0]   spdt;
        bit           ps, run, fl, rdy;
        logic [W-1:0] dtc;
    } vec_t;

    vec_t exp_q[$];
    vec_t drain_tbl[8];
    vec_t fault_tbl[5];

    always #5 clk = ~clk;

    pwm_phase_sequencer #(.W(W), .RST_PERIOD(100), .RST_DUTY(50), .RST_DEAD(5)) dut (
        .MClk_i(clk), .RstN_i(rstn), .Enable_i(en), .Fault_i(flt), .FaultClr_i(fclr),
        .CfgValid_i(cv), .CfgReady_o(rdy), .CfgPeriod_i(cp), .CfgDuty_i(cd), .CfgDead_i(cdd),
        .SPDT_o(spdt), .DeadTimeCount_o(dtc), .PeriodStart_o(ps), .Running_o(running),
        .FaultLatched_o(flatched)
    );

    function automatic vec_t mk(bit r, bit e, bit f, bit fc, bit v, int p, int d, int dd,
                                logic [1:0] s, bit eps, bit erun, bit efl, bit erdy, int edtc);
        vec_t x;
        x.rstn = r; x.en = e; x.flt = f; x.fclr = fc; x.cv = v;
        x.cp = W'(p); x.cd = W'(d); x.cdd = W'(dd);
        x.spdt = s; x.ps = eps; x.run = erun; x.fl = efl; x.rdy = erdy; x.dtc = W'(edtc);
        return x;
    endfunction

    task automatic step(input vec_t v, input string name);
        vec_t e;
        rstn = v.rstn; en = v.en; flt = v.flt; fclr = v.fclr; cv = v.cv;
        cp = v.cp; cd = v.cd; cdd = v.cdd;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({spdt, ps, running, flatched, rdy, dtc} !== {e.spdt, e.ps, e.run, e.fl, e.rdy, e.dtc}) begin
            errors++;
            $display("FAIL %s t=%0t got spdt=%b ps=%b run=%b flt=%b rdy=%b dtc=%0d want spdt=%b ps=%b run=%b flt=%b rdy=%b dtc=%0d",
                     name, $time, spdt, ps, running, flatched, rdy, dtc,
                     e.spdt, e.ps, e.run, e.fl, e.rdy, e.dtc);
        end
    endtask

    // Enabled run with no cfg offered; counter position follows from start/period.
    task automatic run_cycles(input int n, input int per, input int duty, input int dt,
                              input int start, input bit erdy, input string name);
        for (int i = 0; i < n; i++) begin
            int c;
            c = (start + i) % per;
            step(mk(1, 1, 0, 0, 0, 0, 0, 0, (c < duty) ? 2'b10 : 2'b01, c == 0, 1, 0, erdy, dt), name);
        end
    endtask

    initial begin
        drain_tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 5);
        drain_tbl[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 5);
        drain_tbl[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 5);
        drain_tbl[3] = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 5);
        drain_tbl[4] = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 5);
        drain_tbl[5] = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 5);
        drain_tbl[6] = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 5);
        drain_tbl[7] = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 1, 1, 0, 1, 5);

        fault_tbl[0] = mk(1, 1, 1, 0, 1, 10, 4, 7, 2'b00, 0, 0, 1, 0, 3);
        fault_tbl[1] = mk(1, 1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 7);
        fault_tbl[2] = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 7);
        fault_tbl[3] = mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 7);
        fault_tbl[4] = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 1, 1, 0, 1, 7);

        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 5), "reset0");
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 5), "reset1");

        run_cycles(200, 100, 50, 5, 0, 1, "default_pwm");

        run_cycles(11, 100, 50, 5, 0, 1, "pre_drain");
        for (int i = 0; i < 8; i++) step(drain_tbl[i], $sformatf("drain%0d", i));

        run_cycles(29, 100, 50, 5, 1, 1, "pre_cfg");
        step(mk(1, 1, 0, 0, 1, 20, 5, 3, 2'b10, 0, 1, 0, 0, 5), "cfg_accept");
        run_cycles(69, 100, 50, 5, 31, 0, "cfg_pending");
        run_cycles(40, 20, 5, 3, 0, 1, "cfg_applied");

        step(mk(1, 1, 0, 0, 1, 20, 0, 3, 2'b10, 1, 1, 0, 0, 3), "duty0_accept");
        run_cycles(19, 20, 5, 3, 1, 0, "duty0_pending");
        run_cycles(40, 20, 0, 3, 0, 1, "duty0");
        step(mk(1, 1, 0, 0, 1, 20, 25, 3, 2'b01, 1, 1, 0, 0, 3), "duty25_accept");
        run_cycles(19, 20, 0, 3, 1, 0, "duty25_pending");
        run_cycles(40, 20, 25, 3, 0, 1, "duty25");
        step(mk(1, 1, 0, 0, 1, 1, 1, 3, 2'b10, 1, 1, 0, 0, 3), "per1_accept");
        run_cycles(19, 20, 25, 3, 1, 0, "per1_pending");
        run_cycles(6, 2, 1, 3, 0, 1, "per_clamp2");

        for (int i = 0; i < 5; i++) step(fault_tbl[i], $sformatf("fault%0d", i));
        run_cycles(10, 10, 4, 7, 1, 1, "post_fault");

        run_cycles(9, 10, 4, 7, 1, 1, "pre_rst");
        step(mk(1, 1, 0, 0, 1, 30, 10, 9, 2'b10, 1, 1, 0, 0, 7), "rst_cfg_accept");
        run_cycles(2, 10, 4, 7, 1, 0, "rst_cfg_pending");
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 5), "mid_reset");
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 1, 1, 0, 1, 5), "post_reset_run");
        run_cycles(100, 100, 50, 5, 1, 1, "post_reset_pwm");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
